cache_controller: RTL
=====================

// Module: cache_controller
// PURPOSE
//   Direct-mapped, write-through, no-write-allocate cache sitting between the CPU request port and the main-memory RAM.
//   One word per line. Drives the RAM's wr_en/rd_en/addr/w_data and consumes its r_data, which is registered with 1-cycle latency.
//   One request in flight at a time. Saturating hit/miss counters for performance monitoring.
// PARAMETERS
//   DATA_WIDTH  32  word width; equals the RAM DATA_WIDTH
//   ADDR_WIDTH  16  word address width; equals the RAM ADDR_WIDTH
//   INDEX_BITS  6   line index width; 2**INDEX_BITS lines; TAG_BITS = ADDR_WIDTH-INDEX_BITS
// PORTS
//   clk             in   1           rising-edge clock
//   rst_n           in   1           asynchronous, active-low reset
//   cpu_req_valid   in   1           CPU request present
//   cpu_req_we      in   1           1=write, 0=read
//   cpu_req_addr    in   ADDR_WIDTH  word address
//   cpu_req_wdata   in   DATA_WIDTH  write data
//   cpu_req_ready   out  1           controller accepts the request this cycle
//   cpu_resp_valid  out  1           1-cycle pulse: request complete
//   cpu_resp_rdata  out  DATA_WIDTH  read data; 0 when not a read response
//   inv_all         in   1           pulse: invalidate all lines
//   mem_wr_en       out  1           to RAM wr_en
//   mem_rd_en       out  1           to RAM rd_en
//   mem_addr        out  ADDR_WIDTH  to RAM addr
//   mem_w_data      out  DATA_WIDTH  to RAM w_data
//   mem_r_data      in   DATA_WIDTH  from RAM r_data
//   hit_cnt         out  16          hits, saturates at 16'hFFFF
//   miss_cnt        out  16          misses, saturates at 16'hFFFF
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, all valid bits=0, counters=0, latched request=0.
//     All mem_* and cpu_resp_* outputs are 0 immediately. Reset mid-miss abandons the fill; no line is written.
//   Address split: index=addr[INDEX_BITS-1:0]; tag=addr[ADDR_WIDTH-1:INDEX_BITS]. Tag/valid/data arrays use flops with async read.
//   FSM (registered state):
//   IDLE:   cpu_req_ready=1 unless inv_all=1.
//     inv_all=1: clear all valid bits at the edge; request not accepted. Flush has priority.
//     else valid&ready: latch we/addr/wdata, go to LOOKUP.
//   LOOKUP: ready=0; hit = valid[idx] && tag[idx]==latched tag.
//     read hit:   resp_valid=1, rdata=data[idx]; hit_cnt++; go to IDLE.
//     read miss:  mem_rd_en=1, mem_addr=latched addr; miss_cnt++; go to FILL.
//     write:      mem_wr_en=1, mem_addr/mem_w_data=latched; resp_valid=1; go to IDLE.
//       write hit:  also update data[idx]; hit_cnt++.
//       write miss: line untouched; miss_cnt++.
//   FILL:   ready=0; mem_r_data valid this cycle.
//     At the edge: write data[idx], tag[idx], valid[idx]=1.
//     Same cycle: resp_valid=1, rdata=mem_r_data; go to IDLE.
//   Latency from accept edge: hit/write resp in the next cycle; read miss resp 2 cycles after accept.
//   Throughput: one request per 2 cycles (hit) or 3 cycles (miss).
//   cpu_req_ready depends only on state and inv_all. There is no combinational path from cpu_req_* to any output.
//   mem_* and cpu_resp_* decode combinationally from state and latched registers. Outside the listed cases they are 0.
//   inv_all outside IDLE is ignored. The CPU holds it until accepted.
//   Counters stick at 16'hFFFF. No wrap.
// STRUCTURE
//   cache_pkg: state enum {IDLE,LOOKUP,FILL}; TAG_BITS/NUM_LINES derivation functions; counter width constant CNT_W=16.
//   Sub-module cache_tag_store: valid+tag arrays, async lookup, hit output, single-line fill, flush-all.
//   The data array, FSM and counters stay in cache_controller.
// TESTING
//   Read 0x0040 cold (RAM[0x0040]=0xDEADBEEF) -> mem_rd_en 1 cycle; resp rdata 0xDEADBEEF 2 cycles after accept; miss_cnt=1.
//   Re-read 0x0040 -> resp next cycle with 0xDEADBEEF; no mem_rd_en; hit_cnt=1.
//   Write 0x0040=0x12345678, then read -> mem_wr_en with that data; read hits and returns 0x12345678.
//   Read 0x0080 (same index 0, different tag) after 0x0040 -> miss, line replaced; re-read 0x0040 misses again.
//   Write miss to 0x1000 then read 0x1000 -> write reaches RAM, no allocate; read is a miss returning 0x1000's new value.
//   inv_all with cpu_req_valid in IDLE -> ready=0 that cycle; next read of 0x0040 misses.
//   rst_n low during FILL -> outputs 0 at once; line not valid after reset.
//   Force hit_cnt to 0xFFFF, then hit -> stays 0xFFFF.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and derived geometry for the direct-mapped write-through cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        FILL   = 2'd2
    } state_t;

    localparam int CNT_W = 16;

    function automatic int tag_bits(input int addr_width, input int index_bits);
        return addr_width - index_bits;
    endfunction

    function automatic int num_lines(input int index_bits);
        return 1 << index_bits;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cache_controller_if.sv
// CPU request/response and RAM bus; master = CPU/RAM side, slave = cache controller.
interface cache_controller_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic                  cpu_req_valid;
    logic                  cpu_req_we;
    logic [ADDR_WIDTH-1:0] cpu_req_addr;
    logic [DATA_WIDTH-1:0] cpu_req_wdata;
    logic                  cpu_req_ready;
    logic                  cpu_resp_valid;
    logic [DATA_WIDTH-1:0] cpu_resp_rdata;
    logic                  mem_wr_en;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_w_data;
    logic [DATA_WIDTH-1:0] mem_r_data;

    modport master (
        output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata, mem_r_data,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
        input  mem_wr_en, mem_rd_en, mem_addr, mem_w_data
    );

    modport slave (
        input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata, mem_r_data,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
        output mem_wr_en, mem_rd_en, mem_addr, mem_w_data
    );
endinterface

// File: rtl/cache_tag_store.sv
// Valid + tag arrays in flops: async hit lookup, single-line fill, flush-all.
// Zero-cycle lookup; fill/flush take effect at the clock edge; flush beats fill.
module cache_tag_store
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_fill,
    input  logic                  i_flush,
    output logic                  o_hit
);
    localparam int TAG_BITS  = tag_bits(ADDR_WIDTH, INDEX_BITS);
    localparam int NUM_LINES = num_lines(INDEX_BITS);

    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_BITS-1:0]  r_tag [NUM_LINES];
    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_BITS-1:0]   w_tag;

    assign w_idx = i_addr[INDEX_BITS-1:0];
    assign w_tag = i_addr[ADDR_WIDTH-1:INDEX_BITS];
    assign o_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < NUM_LINES; i++) r_tag[i] <= '0;
        end else if (i_flush) begin
            r_valid <= '0;
        end else if (i_fill) begin
            r_valid[w_idx] <= 1'b1;
            r_tag[w_idx]   <= w_tag;
        end
    end
endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache, one word per line, one request in flight.
// Hit/write respond 1 cycle after accept, read miss 2 cycles; ready only in IDLE without a flush.
module cache_controller
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int INDEX_BITS = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    cache_controller_if.slave bus,
    input  logic             inv_all,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    localparam int NUM_LINES = num_lines(INDEX_BITS);

    state_t                r_state;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_data [NUM_LINES];
    logic [CNT_W-1:0]      r_hit_cnt;
    logic [CNT_W-1:0]      r_miss_cnt;

    logic                  w_hit;
    logic                  w_flush;
    logic                  w_fill;
    logic [INDEX_BITS-1:0] w_idx;

    assign w_idx   = r_addr[INDEX_BITS-1:0];
    assign w_flush = (r_state == IDLE) && inv_all;
    assign w_fill  = (r_state == FILL);

    cache_tag_store #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INDEX_BITS (INDEX_BITS)
    ) u_tags (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_addr  (r_addr),
        .i_fill  (w_fill),
        .i_flush (w_flush),
        .o_hit   (w_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!inv_all && bus.cpu_req_valid) begin
                        r_we    <= bus.cpu_req_we;
                        r_addr  <= bus.cpu_req_addr;
                        r_wdata <= bus.cpu_req_wdata;
                        r_state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (w_hit) r_hit_cnt  <= sat_inc(r_hit_cnt);
                    else       r_miss_cnt <= sat_inc(r_miss_cnt);
                    r_state <= (!r_we && !w_hit) ? FILL : IDLE;
                end
                FILL:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Data array needs no reset: a line is only read once its valid bit is set.
    always_ff @(posedge clk) begin
        if (r_state == LOOKUP && r_we && w_hit) r_data[w_idx] <= r_wdata;
        else if (w_fill)                        r_data[w_idx] <= bus.mem_r_data;
    end

    always_comb begin
        bus.cpu_req_ready  = (r_state == IDLE) && !inv_all;
        bus.cpu_resp_valid = 1'b0;
        bus.cpu_resp_rdata = '0;
        bus.mem_wr_en      = 1'b0;
        bus.mem_rd_en      = 1'b0;
        bus.mem_addr       = '0;
        bus.mem_w_data     = '0;
        case (r_state)
            LOOKUP: begin
                if (r_we) begin
                    bus.mem_wr_en      = 1'b1;
                    bus.mem_addr       = r_addr;
                    bus.mem_w_data     = r_wdata;
                    bus.cpu_resp_valid = 1'b1;
                end else if (w_hit) begin
                    bus.cpu_resp_valid = 1'b1;
                    bus.cpu_resp_rdata = r_data[w_idx];
                end else begin
                    bus.mem_rd_en = 1'b1;
                    bus.mem_addr  = r_addr;
                end
            end
            FILL: begin
                bus.cpu_resp_valid = 1'b1;
                bus.cpu_resp_rdata = bus.mem_r_data;
            end
            default: ;
        endcase
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
endmodule
